rng_lcg_mc: RTL and testbench
=============================

Name: rng_lcg_mc

Overview:
Multi-channel, width-parametrised linear congruential generator, successor to the single-channel fixed-constant LCG in the RNG test harness. CHANNELS independent states advance in lockstep. Each state has its own runtime-loadable seed, and the generator has shared multiplier and increment. Samples leave on a valid/ready stream feeding the statistical test blocks, with a stop/drain FSM and a transfer counter.

Parameters:
WIDTH, 32, state/multiplier/increment width in bits (>=8)
CHANNELS, 4, number of parallel generator states (>=1)
OUT_W, 16, output bits per channel, taken from state MSBs (1..WIDTH)
DEF_A, 1103515245, reset multiplier
DEF_C, 12345, reset increment
DEF_SEED, 1, reset seed; channel i resets to DEF_SEED+i mod 2^WIDTH
CH_W, max(1,clog2(CHANNELS)), channel select width (derived)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  config write strobe (honoured only in IDLE)
cfg_sel  in  2  0=seed[cfg_ch], 1=multiplier A, 2=increment C, 3=reserved (ignored)
cfg_ch  in  CH_W  channel for seed writes; values >=CHANNELS ignored
cfg_data  in  WIDTH  config value
start  in  1  pulse: IDLE->RUN
stop  in  1  pulse: RUN->DRAIN
out_data  out  CHANNELS*OUT_W  channel i in bits [i*OUT_W +: OUT_W]
out_valid  out  1  sample valid
out_ready  in  1  consumer accepts
state_o  out  2  0=IDLE, 1=RUN, 2=DRAIN
xfer_cnt  out  32  accepted samples since last start, wraps at 2^32

Behaviour:
- Reset (async assert, sync-clean deassert): state IDLE; x[i]=DEF_SEED+i; A=DEF_A; C=DEF_C; out_data=0; out_valid=0; xfer_cnt=0.
- Step function: next(x) = (A*x + C) mod 2^WIDTH, full WIDTH x WIDTH product truncated to low WIDTH bits. Single-cycle combinational; no pipelining.
- Sample k of channel i = x_k[i][WIDTH-1 -: OUT_W]. Sample 0 is the seed's MSBs.
- IDLE:
  - out_valid=0.
  - cfg_we writes the selected register; the new value is visible the next cycle.
  - start at edge t: out_data<=MSBs(x), x<=next(x), out_valid<=1, xfer_cnt<=0, state<=RUN. Samples therefore appear at t+1.
  - start and cfg_we in the same cycle: config write occurs; start uses the pre-write values.
- RUN:
  - Transfer = out_valid & out_ready.
  - On transfer: out_data<=MSBs(x), x<=next(x), xfer_cnt++.
  - No transfer: out_data, x and out_valid hold. Valid never drops without acceptance.
  - cfg_we ignored. start ignored.
  - stop: state<=DRAIN. If stop coincides with a transfer, that transfer completes normally, the new sample is loaded, and it must still be drained.
- DRAIN:
  - out_valid stays 1 until transfer.
  - On transfer: out_valid<=0, xfer_cnt++, x not advanced, state<=IDLE.
  - stop and start ignored.
- Resume after IDLE continues from the current x; generator state is not re-seeded unless written.
- All channels advance together; there is no per-channel enable.
- xfer_cnt wraps 0xFFFFFFFF->0.
- rst mid-RUN/DRAIN: immediate return to the reset values above; an in-flight sample is discarded.

Decomposition:
- Package rng_pkg: state encodings (ST_IDLE, ST_RUN, ST_DRAIN), cfg_sel codes (CFG_SEED, CFG_MULT, CFG_INCR), default constants.
- Sub-module lcg_step (WIDTH): purely combinational next = A*x + C truncated. Instantiated CHANNELS times via generate.
- Top holds FSM, config registers, output register and counter.

Test Plan:
- Reset defaults, start, out_ready=1: cycle 1 ch0=0x0000, ch1=0x0000; cycle 2 ch0=0x41C6 (x=0x41C67EA6), ch1=0x838C (x=0x838CCD13); xfer_cnt increments every cycle.
- Backpressure: out_ready low 5 cycles mid-stream -> out_data and out_valid stable; sequence resumes with no skipped or duplicated sample (compare to golden model).
- Config:
  - In IDLE write A=1, C=1, seed[0]=0xFFFFFFFF, then start.
  - ch0 samples 0xFFFF, 0x0000, 0x0000, 0x0000 (x: FFFFFFFF, 0, 1, 2). Wrap check.
  - cfg_we asserted during RUN -> no change.
- Stop with ready low: out_valid held in DRAIN until ready; one extra xfer_cnt, then IDLE with out_valid=0. Stop coincident with a transfer -> exactly one further sample delivered.
- Async rst pulsed mid-RUN between clock edges: outputs reset immediately. Subsequent start reproduces the test-1 sequence.
- Parameter sweep WIDTH=16, CHANNELS=1, OUT_W=16, OUT_W=WIDTH: samples equal full state, matching the golden model for 1000 steps.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared encodings and reset constants for the multi-channel LCG.
package rng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CFG_SEED = 2'd0,
    CFG_MULT = 2'd1,
    CFG_INCR = 2'd2,
    CFG_RSVD = 2'd3
  } cfg_sel_e;

  localparam logic [31:0] RNG_DEF_A    = 32'd1103515245;
  localparam logic [31:0] RNG_DEF_C    = 32'd12345;
  localparam logic [31:0] RNG_DEF_SEED = 32'd1;

endpackage

// File: rtl/lcg_step.sv
// One LCG step: next = A*x + C, keeping only the low WIDTH bits of the product sum.
module lcg_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] next_o
);

  assign next_o = a_i * x_i + c_i;

endmodule

// File: rtl/rng_lcg_mc.sv
// Multi-channel LCG with runtime-loadable seeds and shared A/C, streamed out
// over valid/ready with a run/stop/drain controller and a transfer counter.
module rng_lcg_mc
  import rng_pkg::*;
#(
  parameter int unsigned     WIDTH    = 32,
  parameter int unsigned     CHANNELS = 4,
  parameter int unsigned     OUT_W    = 16,
  parameter logic [WIDTH-1:0] DEF_A    = WIDTH'(RNG_DEF_A),
  parameter logic [WIDTH-1:0] DEF_C    = WIDTH'(RNG_DEF_C),
  parameter logic [WIDTH-1:0] DEF_SEED = WIDTH'(RNG_DEF_SEED),
  localparam int unsigned    CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [1:0]                cfg_sel,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [WIDTH-1:0]          cfg_data,
  input  logic                      start,
  input  logic                      stop,
  output logic [CHANNELS*OUT_W-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [1:0]                state_o,
  output logic [31:0]               xfer_cnt
);

  state_e                    state_q, state_d;
  logic [WIDTH-1:0]          x_q [CHANNELS];
  logic [WIDTH-1:0]          x_d [CHANNELS];
  logic [WIDTH-1:0]          x_next [CHANNELS];
  logic [WIDTH-1:0]          a_q, a_d, c_q, c_d;
  logic [CHANNELS*OUT_W-1:0] data_q, data_d;
  logic                      valid_q, valid_d;
  logic [31:0]               cnt_q, cnt_d;
  logic                      xfer, load;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_step
    lcg_step #(.WIDTH(WIDTH)) u_step (
      .a_i   (a_q),
      .x_i   (x_q[g]),
      .c_i   (c_q),
      .next_o(x_next[g])
    );
  end

  assign xfer = valid_q & out_ready;

  // Controller next state, sample load/advance, and IDLE-only config writes.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    c_d     = c_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) x_d[i] = x_q[i];

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          load    = 1'b1;
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          load  = 1'b1;
          cnt_d = cnt_q + 32'd1;
        end
        if (stop) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (xfer) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        data_d[i*OUT_W +: OUT_W] = x_q[i][WIDTH-1 -: OUT_W];
        x_d[i]                   = x_next[i];
      end
    end

    // Applied after the load so a start in the same cycle samples and steps
    // with the pre-write values while the written register still updates.
    if (state_q == ST_IDLE && cfg_we) begin
      unique case (cfg_sel_e'(cfg_sel))
        CFG_SEED: begin
          for (int unsigned i = 0; i < CHANNELS; i++)
            if (cfg_ch == CH_W'(i)) x_d[i] = cfg_data;
        end
        CFG_MULT: a_d = cfg_data;
        CFG_INCR: c_d = cfg_data;
        default:  ;
      endcase
    end
  end

  // State, generator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= DEF_A;
      c_q     <= DEF_C;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) x_q[i] <= DEF_SEED + WIDTH'(i);
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      c_q     <= c_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      for (int unsigned i = 0; i < CHANNELS; i++) x_q[i] <= x_d[i];
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign state_o   = state_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_rng_lcg_mc.sv
// Bench for rng_lcg_mc: a 4x32-bit instance under randomized traffic and a
// 16-bit single-channel instance streaming continuously, both against models.
module tb_rng_lcg_mc;

  logic        clk = 1'b0;
  logic        rst, cfg_we, start, stop, out_ready;
  logic [1:0]  cfg_sel, cfg_ch;
  logic [31:0] cfg_data;
  logic [63:0] out_data;
  logic        out_valid;
  logic [1:0]  state_o;
  logic [31:0] xfer_cnt;

  logic        rst2, start2;
  logic [15:0] out_data2;
  logic        out_valid2;
  logic [1:0]  state2;
  logic [31:0] xfer_cnt2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  bit          cmp_en   = 1'b0;

  always #5 clk = ~clk;

  rng_lcg_mc dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_ch(cfg_ch),
    .cfg_data(cfg_data), .start(start), .stop(stop), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .state_o(state_o), .xfer_cnt(xfer_cnt)
  );

  rng_lcg_mc #(.WIDTH(16), .CHANNELS(1), .OUT_W(16)) dut16 (
    .clk(clk), .rst(rst2), .cfg_we(1'b0), .cfg_sel(2'd0), .cfg_ch(1'b0),
    .cfg_data(16'd0), .start(start2), .stop(1'b0), .out_data(out_data2),
    .out_valid(out_valid2), .out_ready(1'b1), .state_o(state2), .xfer_cnt(xfer_cnt2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lcg32(input logic [31:0] a, x, c);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, x} + {32'd0, c};
    return p[31:0];
  endfunction

  function automatic logic [15:0] lcg16(input logic [15:0] a, x, c);
    logic [31:0] p;
    p = {16'd0, a} * {16'd0, x} + {16'd0, c};
    return p[15:0];
  endfunction

  // Reference model for the 4-channel instance: a stream of samples drawn from
  // per-channel sequences; the generator only moves when a sample is emitted.
  int          m_state;
  logic [31:0] m_x [4];
  logic [31:0] m_a, m_c, m_cnt;
  logic [63:0] m_data;
  bit          m_valid, m_fire;

  task automatic emit();
    for (int i = 0; i < 4; i++) begin
      m_data[i*16 +: 16] = m_x[i][31:16];
      m_x[i] = lcg32(m_a, m_x[i], m_c);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state = 0; m_a = 32'd1103515245; m_c = 32'd12345;
      for (int i = 0; i < 4; i++) m_x[i] = 32'(1 + i);
      m_valid = 1'b0; m_data = '0; m_cnt = '0;
    end else begin
      m_fire = m_valid && out_ready;
      if (m_state == 0) begin
        if (start) begin emit(); m_valid = 1'b1; m_cnt = '0; m_state = 1; end
        if (cfg_we) begin
          if (cfg_sel == 2'd0) m_x[cfg_ch] = cfg_data;
          else if (cfg_sel == 2'd1) m_a = cfg_data;
          else if (cfg_sel == 2'd2) m_c = cfg_data;
        end
      end else if (m_state == 1) begin
        if (m_fire) begin emit(); m_cnt++; end
        if (stop) m_state = 2;
      end else if (m_fire) begin
        m_valid = 1'b0; m_cnt++; m_state = 0;
      end
    end
  end

  // Reference for the 16-bit instance: after start every cycle emits the full state.
  logic [15:0] m2_x, m2_data;
  bit          m2_valid;
  logic [31:0] m2_cnt;

  always @(posedge clk or posedge rst2) begin
    if (rst2) begin
      m2_x = 16'd1; m2_data = '0; m2_valid = 1'b0; m2_cnt = '0;
    end else if (m2_valid || start2) begin
      if (m2_valid) m2_cnt++; else m2_cnt = '0;
      m2_valid = 1'b1;
      m2_data  = m2_x;
      m2_x     = lcg16(16'h4E6D, m2_x, 16'h3039);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("valid", 64'(out_valid), 64'(m_valid));
      chk("state", 64'(state_o), 64'(m_state));
      chk("data", out_data, m_data);
      chk("cnt", 64'(xfer_cnt), 64'(m_cnt));
      chk("w16_valid", 64'(out_valid2), 64'(m2_valid));
      chk("w16_data", 64'(out_data2), 64'(m2_data));
      chk("w16_cnt", 64'(xfer_cnt2), 64'(m2_cnt));
      chk("w16_state", 64'(state2), m2_valid ? 64'd1 : 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [1:0] ch, input logic [31:0] d);
    cfg_we = 1'b1; cfg_sel = sel; cfg_ch = ch; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic rand_cycle(input bit allow_cfg);
    out_ready = ($urandom_range(0, 3) != 0);
    start     = ($urandom_range(0, 15) == 0);
    stop      = ($urandom_range(0, 15) == 0);
    cfg_we    = allow_cfg && ($urandom_range(0, 3) == 0);
    cfg_sel   = 2'($urandom_range(0, 3));
    cfg_ch    = 2'($urandom_range(0, 3));
    cfg_data  = $urandom;
    if (start && cfg_we && cfg_sel == 2'd0) cfg_we = 1'b0;
    tick();
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
  endtask

  // From any state, leaves the controller in IDLE.
  task automatic go_idle();
    out_ready = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic first_two_samples(input string tag);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_s0"}, out_data[31:0], 32'h0000_0000);
    chk({tag, "_cnt0"}, 64'(xfer_cnt), 64'd0);
    chk({tag, "_run"}, 64'(state_o), 64'd1);
    tick();
    chk({tag, "_s1_ch0"}, 64'(out_data[15:0]), 64'h41C6);
    chk({tag, "_s1_ch1"}, 64'(out_data[31:16]), 64'h838C);
    chk({tag, "_cnt1"}, 64'(xfer_cnt), 64'd1);
  endtask

  initial begin
    rst = 1'b1; rst2 = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_ch = '0; cfg_data = '0;
    start = 1'b0; stop = 1'b0; out_ready = 1'b0; start2 = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_cnt", 64'(xfer_cnt), 64'd0);
    chk("rst_state", 64'(state_o), 64'd0);
    rst = 1'b0; rst2 = 1'b0;
    tick();
    cmp_en = 1'b1;

    start2 = 1'b1;
    first_two_samples("t1");
    start2 = 1'b0;
    chk("w16_s2", 64'(out_data2), 64'h7EA6);

    // Backpressure window mid-stream.
    repeat (3) tick();
    out_ready = 1'b0;
    repeat (5) tick();
    out_ready = 1'b1;
    repeat (5) tick();

    repeat (150) rand_cycle(1'b1);

    // Stop while the consumer stalls.
    go_idle();
    start = 1'b1; tick(); start = 1'b0;
    out_ready = 1'b0; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("drain_state", 64'(state_o), 64'd2);
    chk("drain_valid", 64'(out_valid), 64'd1);
    repeat (3) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_done_state", 64'(state_o), 64'd0);
    chk("drain_done_valid", 64'(out_valid), 64'd0);

    // A=1, C=1, seed0 = all ones: ch0 wraps through zero.
    cfg_write(2'd1, 2'd0, 32'd1);
    cfg_write(2'd2, 2'd0, 32'd1);
    cfg_write(2'd0, 2'd0, 32'hFFFF_FFFF);
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("wrap_s0", 64'(out_data[15:0]), 64'hFFFF);
    cfg_we = 1'b1; cfg_sel = 2'd1; cfg_data = 32'd5;
    tick();
    chk("wrap_s1", 64'(out_data[15:0]), 64'h0000);
    tick();
    chk("wrap_s2", 64'(out_data[15:0]), 64'h0000);
    cfg_we = 1'b0;
    tick();
    chk("wrap_s3", 64'(out_data[15:0]), 64'h0000);

    // Stop coincident with a transfer: one further sample, then IDLE.
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stopx_state", 64'(state_o), 64'd2);
    chk("stopx_valid", 64'(out_valid), 64'd1);
    tick();
    chk("stopx_idle", 64'(state_o), 64'd0);

    // Start together with an increment write.
    cfg_write(2'd1, 2'd0, 32'd1103515245);
    cfg_we = 1'b1; cfg_sel = 2'd2; cfg_data = 32'd7; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    repeat (100) rand_cycle(1'b0);

    repeat (400) rand_cycle(1'b1);

    // Asynchronous reset between edges while running.
    go_idle();
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_data", out_data, 64'd0);
    chk("arst_cnt", 64'(xfer_cnt), 64'd0);
    chk("arst_state", 64'(state_o), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    first_two_samples("t5");

    repeat (400) rand_cycle(1'b1);
    chk("w16_long_run", 64'(xfer_cnt2 >= 32'd1000), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
